// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch / load-store memory port arbiter.
// Round-robin conflict resolution is selected with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [BE_W-1:0] BE_FULL = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    // State that records which requester owns the outstanding transaction.
    function automatic arb_state_e wait_state(input arb_owner_e owner);
        return (owner == OWN_LS) ? WAIT_LS : WAIT_IF;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner selection between fetch and load/store requests.
// MEM_ARB_RR_EN: a conflict follows the priority input instead of always favouring LS.
module arb_pick (
    input  logic if_req,
    input  logic ls_req,
`ifdef MEM_ARB_RR_EN
    input  logic prio_ls,
`endif
    output logic pick_ls
);

`ifdef MEM_ARB_RR_EN
    assign pick_ls = !if_req || (ls_req && prio_ls);
`else
    assign pick_ls = !if_req || ls_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// MEM_ARB_RR_EN selects round-robin conflict resolution; otherwise LS always wins a conflict.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [BE_W-1:0]   ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_err
);

    arb_state_e state_q, state_d;
    arb_owner_e lock_own_q, lock_own_d;
    arb_owner_e winner;
    logic       lock_q, lock_d;
    logic       err_q, err_d;
    logic       pick_ls;
    logic       grant;

`ifdef MEM_ARB_RR_EN
    arb_owner_e ptr_q, ptr_d;

    arb_pick u_pick (
        .if_req  (if_req),
        .ls_req  (ls_req),
        .prio_ls (ptr_q == OWN_LS),
        .pick_ls (pick_ls)
    );
`else
    arb_pick u_pick (
        .if_req  (if_req),
        .ls_req  (ls_req),
        .pick_ls (pick_ls)
    );
`endif

    // A stalled request keeps its winner, even if the other side starts requesting.
    always_comb begin
        winner  = lock_q ? lock_own_q : (pick_ls ? OWN_LS : OWN_IF);
        mem_req = reset && (if_req || ls_req) && ((state_q == IDLE) || mem_rvalid);
        grant   = mem_req && mem_gnt;

        if (winner == OWN_LS) begin
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_be    = BE_FULL;
            mem_addr  = if_addr;
            mem_wdata = '0;
        end

        if_gnt    = grant && (winner == OWN_IF);
        ls_gnt    = grant && (winner == OWN_LS);
        if_rvalid = reset && (state_q == WAIT_IF) && mem_rvalid;
        ls_rvalid = reset && (state_q == WAIT_LS) && mem_rvalid;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = ls_rvalid ? mem_rdata : '0;
        arb_err   = err_q;
    end

    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = wait_state(winner);
        end else if ((state_q != IDLE) && mem_rvalid) begin
            state_d = IDLE;
        end

        lock_d     = mem_req && !mem_gnt;
        lock_own_d = winner;
        // A response with nothing outstanding is a protocol violation and sticks.
        err_d      = err_q || ((state_q == IDLE) && mem_rvalid);
`ifdef MEM_ARB_RR_EN
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (winner == OWN_LS) ? OWN_IF : OWN_LS;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lock_q     <= 1'b0;
            lock_own_q <= OWN_LS;
            err_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= OWN_LS;
`endif
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            err_q      <= err_d;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_be;
    logic        mem_gnt, mem_rvalid;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_we, arb_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    // Model: outstanding transaction (owner, is-write), sticky error, priority
    // holder for conflicts (1 = LS), and the requester a stalled issue is bound to.
    bit m_out, m_own, m_we, m_err, m_ptr, m_lock, m_lock_own;
    bit g_if, g_ls, g_rv;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_be      (ls_be),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .arb_err    (arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_err = 0; m_ptr = 1; m_lock = 0; m_lock_own = 0;
    endtask

    // One clock cycle: inputs are already driven; check outputs mid-cycle, then advance.
    task automatic step();
        bit exp_req, win, ifrv, lsrv, n_out, n_own, n_we, n_err, n_ptr, n_lock, n_lown;
        #2;
        if (!reset) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_if_gnt", if_gnt, 0);
            chk("rst_ls_gnt", ls_gnt, 0);
            chk("rst_if_rvalid", if_rvalid, 0);
            chk("rst_ls_rvalid", ls_rvalid, 0);
            chk("rst_arb_err", arb_err, 0);
            g_if = 0; g_ls = 0; g_rv = 0;
            @(posedge clk); #1;
            return;
        end
        if (m_lock)                 win = m_lock_own;
        else if (if_req && ls_req)  win = RR ? m_ptr : 1'b1;
        else                        win = ls_req;
        exp_req = (if_req || ls_req) && (!m_out || mem_rvalid);
        ifrv = m_out && !m_own && mem_rvalid;
        lsrv = m_out && m_own && mem_rvalid;

        chk("mem_req", mem_req, exp_req);
        chk("if_gnt", if_gnt, exp_req && mem_gnt && !win);
        chk("ls_gnt", ls_gnt, exp_req && mem_gnt && win);
        if (exp_req) begin
            chk("mem_addr", mem_addr, win ? ls_addr : if_addr);
            chk("mem_we", mem_we, win ? ls_we : 1'b0);
            chk("mem_be", mem_be, win ? ls_be : 4'hF);
            if (win) chk("mem_wdata", mem_wdata, ls_wdata);
        end
        chk("if_rvalid", if_rvalid, ifrv);
        chk("if_rdata", if_rdata, ifrv ? mem_rdata : 32'h0);
        chk("ls_rvalid", ls_rvalid, lsrv);
        if (!(lsrv && m_we)) chk("ls_rdata", ls_rdata, lsrv ? mem_rdata : 32'h0);
        chk("arb_err", arb_err, m_err);

        g_if = exp_req && mem_gnt && !win;
        g_ls = exp_req && mem_gnt && win;
        g_rv = mem_rvalid;

        n_err = m_err || (!m_out && mem_rvalid);
        n_out = m_out; n_own = m_own; n_we = m_we; n_ptr = m_ptr;
        n_lock = 0; n_lown = m_lock_own;
        if (exp_req && mem_gnt) begin
            n_out = 1; n_own = win; n_we = win ? ls_we : 1'b0; n_ptr = !win;
        end else begin
            if (m_out && mem_rvalid) n_out = 0;
            if (exp_req) begin n_lock = 1; n_lown = win; end
        end
        @(posedge clk);
        m_out = n_out; m_own = n_own; m_we = n_we; m_err = n_err;
        m_ptr = n_ptr; m_lock = n_lock; m_lock_own = n_lown;
        #1;
    endtask

    initial begin
        bit exp_ls;
        bit pend;
        int dly;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        reset = 0; model_reset();
        @(posedge clk); #1;

        // Reset holds everything quiet even with requests and a response present
        if_req = 1; ls_req = 1; mem_rvalid = 1; mem_gnt = 1;
        step();
        if_req = 0; ls_req = 0; mem_rvalid = 0;
        reset = 1;
        step();

        // IF-only read with immediate grant and next-cycle response
        if_req = 1; if_addr = 32'h100; mem_gnt = 1;
        #1; chk("d029_if_gnt", if_gnt, 1); chk("d029_addr", mem_addr, 32'h100);
        step();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #1; chk("d029_if_rvalid", if_rvalid, 1); chk("d029_if_rdata", if_rdata, 32'hDEADBEEF);
        step();
        mem_rvalid = 0;
        step();

        // Conflict: LS first, IF issued back-to-back on the LS response
        if_req = 1; if_addr = 32'h200; ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h300;
        #1; chk("d030_ls_first", ls_gnt, 1); chk("d030_if_wait", if_gnt, 0);
        step();
        ls_req = 0; mem_rvalid = 1; mem_rdata = 32'h11111111;
        #1; chk("d030_if_b2b", if_gnt, 1); chk("d030_ls_rvalid", ls_rvalid, 1);
        step();
        if_req = 0; mem_rdata = 32'h22222222;
        #1; chk("d030_if_rvalid", if_rvalid, 1);
        step();
        mem_rvalid = 0;
        step();

        // Four consecutive conflicts with both sides continuously requesting
        exp_ls = 1;
        for (int i = 0; i < 4; i++) begin
            if_req = 1; ls_req = 1; ls_addr = 32'h400 + i; mem_gnt = 1;
            mem_rvalid = (i > 0); mem_rdata = $urandom;
            #1; chk("d030_conf_ls", ls_gnt, exp_ls); chk("d030_conf_if", if_gnt, !exp_ls);
            step();
            if (RR) exp_ls = !exp_ls;
        end
        ls_req = 0; mem_rvalid = 1;
        step();
        if_req = 0;
        step();
        mem_rvalid = 0;
        step();

        // Store stalled by the memory for three cycles
        ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h500; ls_wdata = 32'hCAFEF00D; mem_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("d031_req_held", mem_req, 1);
            chk("d031_be", mem_be, 4'b0011);
            chk("d031_wdata", mem_wdata, 32'hCAFEF00D);
            chk("d031_no_gnt", ls_gnt, 0);
            step();
        end
        mem_gnt = 1;
        #1; chk("d031_gnt", ls_gnt, 1);
        step();
        ls_req = 0; mem_rvalid = 1; mem_rdata = 32'h0;
        #1; chk("d031_ack", ls_rvalid, 1);
        step();
        mem_rvalid = 0;
        step();

        // A stalled IF keeps the port when LS starts requesting
        if_req = 1; if_addr = 32'h600; mem_gnt = 0;
        step();
        ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h700;
        #1; chk("lock_addr", mem_addr, 32'h600);
        step();
        mem_gnt = 1;
        #1; chk("lock_if_gnt", if_gnt, 1); chk("lock_ls_gnt", ls_gnt, 0);
        step();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h33333333;
        #1; chk("lock_ls_b2b", ls_gnt, 1);
        step();
        ls_req = 0; mem_rdata = 32'h44444444;
        step();
        mem_rvalid = 0;
        step();

        // Streaming fetch against a single-cycle memory
        if_req = 1; if_addr = 32'h800; mem_gnt = 1;
        step();
        mem_rvalid = 1;
        for (int i = 0; i < 8; i++) begin
            if_addr = 32'h804 + 4 * i; mem_rdata = $urandom;
            #1;
            chk("d033_if_rvalid", if_rvalid, 1);
            chk("d033_if_gnt", if_gnt, 1);
            chk("d033_one_owner", {if_rvalid, ls_rvalid}, 2'b10);
            step();
        end
        if_req = 0; mem_rdata = $urandom;
        step();
        mem_rvalid = 0;
        step();

        // Random traffic with variable grant stalls and response latency
        pend = 0; dly = 0;
        for (int c = 0; c < 400; c++) begin
            if (g_if || !if_req) begin
                if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
            end
            if (g_ls || !ls_req) begin
                ls_req = ($urandom_range(0, 2) != 0); ls_we = $urandom_range(0, 1);
                ls_be = $urandom_range(0, 15); ls_addr = $urandom; ls_wdata = $urandom;
            end
            if (g_rv) pend = 0;
            if (g_if || g_ls) begin
                pend = 1; dly = $urandom_range(0, 2);
            end else if (pend && dly > 0) begin
                dly--;
            end
            mem_gnt = ($urandom_range(0, 3) != 0);
            mem_rvalid = pend && (dly == 0);
            mem_rdata = $urandom;
            step();
        end
        if (g_rv) pend = 0;
        if (g_if || g_ls) begin pend = 1; dly = 0; end
        if_req = 0; ls_req = 0;
        for (int k = 0; k < 6 && pend; k++) begin
            mem_rvalid = (dly == 0);
            step();
            if (g_rv) pend = 0; else if (dly > 0) dly--;
        end
        mem_rvalid = 0;
        chk("drain_done", pend, 0);
        step();

        // Reset while a load is outstanding; the late response is a stray
        ls_req = 1; ls_we = 0; ls_addr = 32'h900; mem_gnt = 1;
        step();
        ls_req = 0;
        step();
        reset = 0; model_reset();
        step();
        reset = 1; mem_rvalid = 1; mem_rdata = 32'h55555555;
        #1; chk("d032_no_rvalid", ls_rvalid, 0); chk("d032_err_pre", arb_err, 0);
        step();
        mem_rvalid = 0;
        #1; chk("d032_err_set", arb_err, 1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
